// File: rtl/dice_pkg.sv
// Shared types, segment patterns and the die-to-segment decoder for the dice game front end.
package dice_pkg;

  localparam int unsigned DIE_W = 3;
  localparam int unsigned SUM_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    LATCH   = 2'd2
  } state_t;

  typedef logic [DIE_W-1:0] die_t;

  // Segment bit order is gfedcba, 1 = lit
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  function automatic logic [SEG_W-1:0] die_to_seg(input die_t d);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (d)
      3'd1:    seg = SEG_1;
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      3'd5:    seg = SEG_5;
      3'd6:    seg = SEG_6;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stable-sample counter; level moves only after
// DEBOUNCE_CYCLES consecutive samples disagree with it.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic             level_n;

  // Any sample matching the current level restarts the count
  always_comb begin
    cnt_n   = '0;
    level_n = level;
    if (sync_q[1] != level) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_n = sync_q[1];
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_n;
      level  <= level_n;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Dice game front end: debounced roll button, spinning die counters while held,
// latched result with a done strobe, and registered 7-segment patterns.
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          SHOW_SPIN       = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll,
  output logic [DIE_W-1:0] die1,
  output logic [DIE_W-1:0] die2,
  output logic [SUM_W-1:0] sum,
  output logic             roll_done,
  output logic             rolling,
  output logic [SEG_W-1:0] disp1,
  output logic [SEG_W-1:0] disp2
);

  state_t           state_q;
  state_t           state_n;
  die_t             die1_n;
  die_t             die2_n;
  logic [SEG_W-1:0] disp1_n;
  logic [SEG_W-1:0] disp2_n;
  logic             have_result_q;
  logic             have_result_n;
  logic             btn_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (roll),
    .level(btn_level)
  );

  // Next state, die counters and segment patterns all derive from the next state so
  // every output register lines up with the state it describes.
  always_comb begin
    state_n       = state_q;
    die1_n        = die1;
    die2_n        = die2;
    have_result_n = have_result_q;
    disp1_n       = SEG_BLANK;
    disp2_n       = SEG_BLANK;

    case (state_q)
      IDLE:    if (btn_level)  state_n = ROLLING;
      ROLLING: if (!btn_level) state_n = LATCH;
      LATCH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_q == ROLLING) begin
      die1_n = (die1 == 3'd6) ? 3'd1 : die1 + 3'd1;
      if (die1 == 3'd6) begin
        die2_n = (die2 == 3'd6) ? 3'd1 : die2 + 3'd1;
      end
    end

    if (state_n == LATCH) have_result_n = 1'b1;

    if ((state_n == ROLLING && SHOW_SPIN) || (state_n != ROLLING && have_result_n)) begin
      disp1_n = die_to_seg(die1_n);
      disp2_n = die_to_seg(die2_n);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      die1          <= 3'd1;
      die2          <= 3'd1;
      sum           <= 4'd2;
      roll_done     <= 1'b0;
      rolling       <= 1'b0;
      disp1         <= SEG_BLANK;
      disp2         <= SEG_BLANK;
      have_result_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      die1          <= die1_n;
      die2          <= die2_n;
      sum           <= SUM_W'(die1_n) + SUM_W'(die2_n);
      roll_done     <= (state_n == LATCH);
      rolling       <= (state_n == ROLLING);
      disp1         <= disp1_n;
      disp2         <= disp2_n;
      have_result_q <= have_result_n;
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with a short debounce window and hand-computed results.
module tb_dice_roller;

  logic       clock;
  logic       reset;
  logic       roll;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       roll_done;
  logic       rolling;
  logic [6:0] disp1;
  logic [6:0] disp2;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int roll_cyc = 0;
  int via_viol = 0;
  logic prev_done = 1'b0;
  logic prev_rolling = 1'b0;

  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;

  dice_roller #(
    .DEBOUNCE_CYCLES(4),
    .SHOW_SPIN      (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .roll     (roll),
    .die1     (die1),
    .die2     (die2),
    .sum      (sum),
    .roll_done(roll_done),
    .rolling  (rolling),
    .disp1    (disp1),
    .disp2    (disp2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse/cycle counters, plus a check that rolling never rises straight out of LATCH
  always @(negedge clock) begin
    if (roll_done) done_cnt++;
    if (rolling) roll_cyc++;
    if (rolling && !prev_rolling && prev_done) via_viol++;
    prev_done    = roll_done;
    prev_rolling = rolling;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (roll_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_rolling(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (rolling) seen = 1'b1;
    end
    check({tag, "_rolling_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [2:0] d1, input logic [2:0] d2,
                              input logic [3:0] s, input logic [6:0] g1, input logic [6:0] g2);
    check({tag, "_die1"}, 32'(die1), 32'(d1));
    check({tag, "_die2"}, 32'(die2), 32'(d2));
    check({tag, "_sum"}, 32'(sum), 32'(s));
    check({tag, "_disp1"}, 32'(disp1), 32'(g1));
    check({tag, "_disp2"}, 32'(disp2), 32'(g2));
  endtask

  task automatic hold_roll(input int n);
    roll = 1'b1;
    repeat (n) tick();
    roll = 1'b0;
  endtask

  initial begin
    int d0;
    int c0;

    reset = 1'b0;
    roll  = 1'b0;
    repeat (3) tick();
    check_result("reset", 3'd1, 3'd1, 4'd2, 7'b0, 7'b0);
    check("reset_done", 32'(roll_done), 32'd0);
    check("reset_rolling", 32'(rolling), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("idle_blank", 32'(disp1), 32'd0);

    // Roll 1: 7 rolling clocks from (1,1)
    d0 = done_cnt; c0 = roll_cyc;
    hold_roll(7);
    wait_done("r7", 30);
    check_result("r7", 3'd2, 3'd2, 4'd4, S2, S2);
    check("r7_rolling_in_latch", 32'(rolling), 32'd0);
    repeat (4) tick();
    check("r7_done_count", 32'(done_cnt - d0), 32'd1);
    check("r7_roll_cycles", 32'(roll_cyc - c0), 32'd7);
    check_result("r7_idle_hold", 3'd2, 3'd2, 4'd4, S2, S2);

    // Roll 2: 36 clocks is a full lap back to the same pair
    d0 = done_cnt; c0 = roll_cyc;
    hold_roll(36);
    wait_done("r36", 30);
    check_result("r36", 3'd2, 3'd2, 4'd4, S2, S2);
    repeat (4) tick();
    check("r36_roll_cycles", 32'(roll_cyc - c0), 32'd36);
    check("r36_done_count", 32'(done_cnt - d0), 32'd1);

    // Glitch shorter than the debounce window
    d0 = done_cnt; c0 = roll_cyc;
    hold_roll(3);
    repeat (20) tick();
    check("glitch_roll_cycles", 32'(roll_cyc - c0), 32'd0);
    check("glitch_done_count", 32'(done_cnt - d0), 32'd0);
    check_result("glitch_hold", 3'd2, 3'd2, 4'd4, S2, S2);

    // Bounce mid-roll: 10 high, 2 low, 10 high -> 22 rolling clocks, (2,2) -> (6,5)
    d0 = done_cnt; c0 = roll_cyc;
    hold_roll(10);
    check("bounce_pre_rolling", 32'(rolling), 32'd1);
    repeat (2) tick();
    check("bounce_low_rolling", 32'(rolling), 32'd1);
    hold_roll(10);
    check("bounce_post_rolling", 32'(rolling), 32'd1);
    check("bounce_no_done", 32'(done_cnt - d0), 32'd0);
    wait_done("bounce", 30);
    check_result("bounce", 3'd6, 3'd5, 4'd11, S6, S5);
    repeat (4) tick();
    check("bounce_roll_cycles", 32'(roll_cyc - c0), 32'd22);

    // Reset on the 5th rolling clock, button still held through deassert
    d0 = done_cnt;
    roll = 1'b1;
    wait_rolling("rst", 20);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check_result("rst_async", 3'd1, 3'd1, 4'd2, 7'b0, 7'b0);
    check("rst_async_rolling", 32'(rolling), 32'd0);
    check("rst_async_done", 32'(roll_done), 32'd0);
    repeat (3) tick();
    check("rst_held_done", 32'(done_cnt - d0), 32'd0);
    reset = 1'b1;
    c0 = roll_cyc;
    repeat (10) tick();
    roll = 1'b0;
    wait_done("rst_new", 30);
    check_result("rst_new", 3'd5, 3'd2, 4'd7, S5, S2);
    repeat (4) tick();
    check("rst_new_roll_cycles", 32'(roll_cyc - c0), 32'd10);
    check("rst_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: second press starts in the LATCH cycle of the first
    d0 = done_cnt; c0 = roll_cyc;
    hold_roll(8);
    wait_done("b2b_a", 30);
    check_result("b2b_a", 3'd1, 3'd4, 4'd5, S1, S4);
    roll = 1'b1;
    tick();
    check("b2b_idle_done", 32'(roll_done), 32'd0);
    check("b2b_idle_rolling", 32'(rolling), 32'd0);
    repeat (5) tick();
    roll = 1'b0;
    wait_done("b2b_b", 30);
    check_result("b2b_b", 3'd1, 3'd5, 4'd6, S1, S5);
    repeat (4) tick();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_roll_cycles", 32'(roll_cyc - c0), 32'd14);
    check("rolling_via_idle", 32'(via_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
